dmem_responder: RTL and testbench

Data-memory responder for the CPU's data bus: the target side of the daddr/dreq/dwrite/ddata/dready_n/dbusy handshake driven by the memory-access stage. It accepts one word access at a time, inserts a configurable number of wait states, and commits writes or returns read data from an internal word array. It sits at the top level next to the pipeline, in place of the external data memory, in both simulation and FPGA builds.

---
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory target for the MEM-stage dreq/dready_n bus handshake.
// Optional DMEM_ALIGN_CHECK_EN adds the derr port and drops misaligned accesses.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] daddr,
  input  logic        dreq,
  input  logic        dwrite,
  inout  wire  [31:0] ddata,
  output logic        dready_n,
  output logic        dbusy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        derr
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] RL = 4'(READ_LAT - 1);
  localparam logic [3:0] WL = 4'(WRITE_LAT - 1);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wr_q;
  logic                  mis_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata;
  logic                  drive;

  logic [DEPTH_LOG2-1:0] idx_now;
  logic                  wr_now;
  logic                  mis_now;
  logic [31:0]           wdata_now;
  logic [3:0]            load;
  logic                  commit;
  logic                  unused_addr;

  assign unused_addr = ^{daddr[31:DEPTH_LOG2+2], daddr[1:0]};

  // Live request in IDLE, latched attributes otherwise; commit marks the edge into RESP
  always_comb begin
    idx_now   = daddr[DEPTH_LOG2+1:2];
    wr_now    = dwrite;
    mis_now   = ALIGN && (daddr[1:0] != 2'b00);
    wdata_now = ddata;
    load      = dwrite ? WL : RL;
    commit    = 1'b0;
    if (state == IDLE) begin
      commit = dreq && (load == 4'd0);
    end else begin
      idx_now   = idx_q;
      wr_now    = wr_q;
      mis_now   = mis_q;
      wdata_now = wdata_q;
      commit    = (state == WAIT) && (cnt == 4'd1);
    end
  end

  // Access sequencer with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dready_n <= 1'b1;
      dbusy    <= 1'b0;
      drive    <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      derr     <= 1'b0;
`endif
    end else begin
      dready_n <= 1'b1;
      dbusy    <= 1'b0;
      drive    <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      derr     <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (dreq) begin
            idx_q   <= idx_now;
            wr_q    <= dwrite;
            mis_q   <= mis_now;
            wdata_q <= ddata;
            cnt     <= load;
            if (load != 4'd0) begin
              state <= WAIT;
              dbusy <= 1'b1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt != 4'd1) dbusy <= 1'b1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        state    <= RESP;
        dready_n <= 1'b0;
        drive    <= !wr_now;
`ifdef DMEM_ALIGN_CHECK_EN
        derr     <= mis_now;
`endif
        if (!wr_now) rdata <= mis_now ? 32'd0 : mem[idx_now];
      end
    end
  end

  // Array write on the edge entering RESP; suppressed by reset or misalignment
  always_ff @(posedge clk) begin
    if (rst && commit && wr_now && !mis_now) mem[idx_now] <= wdata_now;
  end

  assign ddata = drive ? rdata : 'z;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: random and directed accesses
// checked against a word-array model of the responder.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int RLAT = 2;
  localparam int WLAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dreq = 1'b0;
  logic        dwrite = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] wval = 32'd0;
  logic        wdrive = 1'b0;
  wire  [31:0] ddata;
  logic        dready_n;
  logic        dbusy;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        derr;
`endif

  assign ddata = wdrive ? wval : 'z;

  dmem_responder #(
    .DEPTH_LOG2(12),
    .READ_LAT(RLAT),
    .WRITE_LAT(WLAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .daddr(daddr),
    .dreq(dreq),
    .dwrite(dwrite),
    .ddata(ddata),
    .dready_n(dready_n),
    .dbusy(dbusy)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .derr(derr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    int          lat;
    bit          rd;
    bit          chk;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy window and completion strobe against scoreboard head
  exp_t mon_e;
  bit   mon_busy;
  always @(negedge clk) begin
    if (rst) begin
      mon_busy = sb.size() > 0 && cyc > sb[0].acc && cyc < sb[0].acc + sb[0].lat;
      check("dbusy", {31'd0, dbusy}, {31'd0, mon_busy});
      if (dready_n == 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL strobe: dready_n low with nothing pending (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("latency", 32'(cyc), 32'(mon_e.acc + mon_e.lat));
          if (mon_e.rd && mon_e.chk) check("rdata", ddata, mon_e.data);
`ifdef DMEM_ALIGN_CHECK_EN
          check("derr", {31'd0, derr}, {31'd0, mon_e.err});
`endif
        end
      end
`ifdef DMEM_ALIGN_CHECK_EN
      else check("derr_idle", {31'd0, derr}, 32'd0);
`endif
    end
  end

  // Issue one access starting in the current cycle; waits for its strobe
  task automatic access(input logic [31:0] a, input bit wr,
                        input logic [31:0] d, input bit b2b);
    exp_t e;
    int   idx;
    int   n;
    bit   mis;
    idx   = int'(a >> 2) % 4096;
    mis   = ALIGN && (a % 4 != 0);
    e.acc = cyc;
    e.lat = wr ? WLAT : RLAT;
    e.rd  = !wr;
    e.err = mis;
    e.chk = 1'b0;
    e.data = 32'd0;
    if (wr) begin
      if (!mis) model[idx] = d;
    end else if (mis) begin
      e.chk = 1'b1;
    end else if (model.exists(idx)) begin
      e.chk  = 1'b1;
      e.data = model[idx];
    end
    sb.push_back(e);
    dreq   = 1'b1;
    dwrite = wr;
    daddr  = a;
    wdrive = wr;
    wval   = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (dready_n == 1'b0) break;
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL timeout: no dready_n for addr %h", a);
        break;
      end
      daddr = a ^ 32'h10;
    end
    @(posedge clk);
    #1;
    if (!b2b) begin
      dreq   = 1'b0;
      wdrive = 1'b0;
      daddr  = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] r;
  logic [31:0] a;
  bit          wr;

  initial begin
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_dready_n", {31'd0, dready_n}, 32'd1);
      check("rst_dbusy", {31'd0, dbusy}, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
      check("rst_derr", {31'd0, derr}, 32'd0);
`endif
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    access(32'h100, 1'b1, 32'hDEADBEEF, 1'b0);
    idle(1);
    access(32'h100, 1'b0, 32'd0, 1'b0);
    idle(1);

    access(32'h8, 1'b1, 32'h11111111, 1'b1);
    access(32'h8, 1'b0, 32'd0, 1'b0);
    idle(1);

    access(32'h00004004, 1'b1, 32'hCAFE0004, 1'b0);
    access(32'h4, 1'b0, 32'd0, 1'b0);

    access(32'h20, 1'b1, 32'h20202020, 1'b0);
    access(32'h30, 1'b1, 32'h30303030, 1'b0);
    access(32'h20, 1'b0, 32'd0, 1'b0);

    access(32'h40, 1'b1, 32'hAAAA4040, 1'b0);
    dreq = 1'b1; dwrite = 1'b1; daddr = 32'h40;
    wdrive = 1'b1; wval = 32'h55550000; rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1; dreq = 1'b0; wdrive = 1'b0;
    idle(1);
    dreq = 1'b1; dwrite = 1'b0; daddr = 32'h40;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1; dreq = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("drop_strobe", {31'd0, dready_n}, 32'd1);
    end
    @(posedge clk);
    #1;
    access(32'h40, 1'b0, 32'd0, 1'b0);

    if (ALIGN) begin
      access(32'h102, 1'b1, 32'h0BAD0BAD, 1'b0);
      access(32'h100, 1'b0, 32'd0, 1'b0);
      access(32'h103, 1'b0, 32'd0, 1'b0);
    end

    for (int k = 0; k < 160; k++) begin
      r  = $urandom;
      a  = (r & 32'hFFFFC000) | (32'($urandom_range(0, 15)) << 2);
      if (ALIGN) begin
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      end else begin
        a = a | 32'($urandom_range(0, 3));
      end
      wr = (k < 16) || ($urandom_range(0, 1) == 1);
      if (k < 16) a = (a & 32'hFFFFFFC3) | (32'(k) << 2);
      access(a, wr, $urandom, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        dreq = 1'b0;
        wdrive = 1'b0;
        idle($urandom_range(1, 2));
      end
    end
    dreq = 1'b0;
    wdrive = 1'b0;
    idle(4);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
